// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: instruction layout, opcodes
// and the arbiter FSM state encoding.
package alu_pkg;

    localparam int INSTR_W = 18;
    localparam int DATA_W  = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu8bit.sv
// Combinational 8-bit ALU: instr = {opcode, A, B}; ADD sets carry and signed
// overflow, MUL is signed with {Y,X} holding the 16-bit product.
module alu8bit
    import alu_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  x,
    output logic [DATA_W-1:0]  y,
    output logic               overflow,
    output logic               carry
);

    logic [1:0]                opcode;
    logic [DATA_W-1:0]         a;
    logic [DATA_W-1:0]         b;
    logic [DATA_W:0]           sum;
    logic signed [2*DATA_W-1:0] prod;

    assign opcode = instr[17:16];
    assign a      = instr[15:8];
    assign b      = instr[7:0];
    assign sum    = {1'b0, a} + {1'b0, b};
    assign prod   = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        x        = '0;
        y        = '0;
        overflow = 1'b0;
        carry    = 1'b0;
        case (opcode)
            OP_ADD: begin
                x        = sum[DATA_W-1:0];
                carry    = sum[DATA_W];
                overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_MUL: begin
                x        = prod[DATA_W-1:0];
                y        = prod[2*DATA_W-1:DATA_W];
                overflow = prod[2*DATA_W-1:DATA_W] != {DATA_W{prod[DATA_W-1]}};
            end
            OP_AND:  x = a & b;
            default: x = a ^ b;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Stateless two-way round-robin grant: on a tie the requester that was not
// granted last wins; a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for an external alu8bit: grant, hold the instruction
// for EXEC_CYCLES, capture the result and present it until accepted.
// Optional per-requester grant counters are enabled with ALU_ARB_CNT_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int EXEC_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic [INSTR_W-1:0] req0_instr,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [INSTR_W-1:0] req1_instr,
    output logic               req1_ready,
    output logic [INSTR_W-1:0] alu_instr,
    input  logic [DATA_W-1:0]  alu_x,
    input  logic [DATA_W-1:0]  alu_y,
    input  logic               alu_ovf,
    input  logic               alu_carry,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [DATA_W-1:0]  rsp_x,
    output logic [DATA_W-1:0]  rsp_y,
    output logic               rsp_ovf,
    output logic               rsp_carry
`ifdef ALU_ARB_CNT_EN
    ,
    output logic [15:0]        grant_cnt0,
    output logic [15:0]        grant_cnt1
`endif
);

    localparam logic [1:0] EXEC_LAST = 2'(EXEC_CYCLES - 1);

    state_t             state_q, state_d;
    logic [1:0]         exec_cnt_q, exec_cnt_d;
    logic               last_q, last_d;
    logic [INSTR_W-1:0] alu_instr_q, alu_instr_d;
    logic               rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]  rsp_x_q, rsp_x_d;
    logic [DATA_W-1:0]  rsp_y_q, rsp_y_d;
    logic               rsp_ovf_q, rsp_ovf_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic [1:0]         gnt;

    rr_arb2 u_rr_arb2 (
        .req  ({req1_valid, req0_valid}),
        .last (last_q),
        .gnt  (gnt)
    );

    always_comb begin
        state_d     = state_q;
        exec_cnt_d  = exec_cnt_q;
        last_d      = last_q;
        alu_instr_d = alu_instr_q;
        rsp_id_d    = rsp_id_q;
        rsp_x_d     = rsp_x_q;
        rsp_y_d     = rsp_y_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_carry_d = rsp_carry_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    alu_instr_d = gnt[0] ? req0_instr : req1_instr;
                    rsp_id_d    = gnt[1];
                    last_d      = gnt[1];
                    exec_cnt_d  = '0;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_cnt_q == EXEC_LAST) begin
                    rsp_x_d     = alu_x;
                    rsp_y_d     = alu_y;
                    rsp_ovf_d   = alu_ovf;
                    rsp_carry_d = alu_carry;
                    state_d     = ST_RESP;
                end else begin
                    exec_cnt_d = exec_cnt_q + 2'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            exec_cnt_q  <= '0;
            last_q      <= 1'b1;
            alu_instr_q <= '0;
            rsp_id_q    <= 1'b0;
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            exec_cnt_q  <= exec_cnt_d;
            last_q      <= last_d;
            alu_instr_q <= alu_instr_d;
            rsp_id_q    <= rsp_id_d;
            rsp_x_q     <= rsp_x_d;
            rsp_y_q     <= rsp_y_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end

    assign req0_ready = (state_q == ST_IDLE) && gnt[0];
    assign req1_ready = (state_q == ST_IDLE) && gnt[1];
    assign alu_instr  = alu_instr_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_x      = rsp_x_q;
    assign rsp_y      = rsp_y_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_carry  = rsp_carry_q;

`ifdef ALU_ARB_CNT_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // Saturating: a counter pinned at all-ones stays there until reset.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (req0_ready && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
        if (req1_ready && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with EXEC_CYCLES=1 and 3, each beside a real
// alu8bit; define ALU_ARB_CNT_EN to also exercise the grant counters.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam logic [17:0] I_ADD_33_7   = {OP_ADD, 8'd33, 8'd7};
    localparam logic [17:0] I_ADD_119_57 = {OP_ADD, 8'd119, 8'd57};
    localparam logic [17:0] I_MUL_17_M11 = {OP_MUL, 8'd17, 8'hF5};
    localparam logic [17:0] I_XOR_A5_3C  = {OP_XOR, 8'hA5, 8'h3C};
    localparam logic [17:0] I_AND_F0_3C  = {OP_AND, 8'hF0, 8'h3C};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [2];
    logic        req0_valid [2];
    logic [17:0] req0_instr [2];
    logic        req0_ready [2];
    logic        req1_valid [2];
    logic [17:0] req1_instr [2];
    logic        req1_ready [2];
    logic [17:0] alu_instr  [2];
    logic [7:0]  alu_x      [2];
    logic [7:0]  alu_y      [2];
    logic        alu_ovf    [2];
    logic        alu_carry  [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic        rsp_id     [2];
    logic [7:0]  rsp_x      [2];
    logic [7:0]  rsp_y      [2];
    logic        rsp_ovf    [2];
    logic        rsp_carry  [2];
`ifdef ALU_ARB_CNT_EN
    logic [15:0] grant_cnt0 [2];
    logic [15:0] grant_cnt1 [2];
`endif

    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        alu_arbiter #(.EXEC_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .req0_valid (req0_valid[g]),
            .req0_instr (req0_instr[g]),
            .req0_ready (req0_ready[g]),
            .req1_valid (req1_valid[g]),
            .req1_instr (req1_instr[g]),
            .req1_ready (req1_ready[g]),
            .alu_instr  (alu_instr[g]),
            .alu_x      (alu_x[g]),
            .alu_y      (alu_y[g]),
            .alu_ovf    (alu_ovf[g]),
            .alu_carry  (alu_carry[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_id     (rsp_id[g]),
            .rsp_x      (rsp_x[g]),
            .rsp_y      (rsp_y[g]),
            .rsp_ovf    (rsp_ovf[g]),
            .rsp_carry  (rsp_carry[g])
`ifdef ALU_ARB_CNT_EN
            ,
            .grant_cnt0 (grant_cnt0[g]),
            .grant_cnt1 (grant_cnt1[g])
`endif
        );

        alu8bit u_alu (
            .instr    (alu_instr[g]),
            .x        (alu_x[g]),
            .y        (alu_y[g]),
            .overflow (alu_ovf[g]),
            .carry    (alu_carry[g])
        );
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are read on the falling edge.
    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs(input int d);
        req0_valid[d] = 1'b0;
        req0_instr[d] = '0;
        req1_valid[d] = 1'b0;
        req1_instr[d] = '0;
        rsp_ready[d]  = 1'b1;
    endtask

    task automatic do_reset(input int d);
        drive();
        rst_n[d] = 1'b0;
        drive();
        rst_n[d] = 1'b1;
    endtask

    task automatic check_reset(input int d, input string tag);
        chk_w({tag, "_alu_instr"}, 32'(alu_instr[d]), 32'h0);
        chk_b({tag, "_rsp_valid"}, rsp_valid[d], 1'b0);
        chk_b({tag, "_rsp_id"}, rsp_id[d], 1'b0);
        chk_w({tag, "_rsp_x"}, 32'(rsp_x[d]), 32'h0);
        chk_w({tag, "_rsp_y"}, 32'(rsp_y[d]), 32'h0);
        chk_b({tag, "_rsp_ovf"}, rsp_ovf[d], 1'b0);
        chk_b({tag, "_rsp_carry"}, rsp_carry[d], 1'b0);
`ifdef ALU_ARB_CNT_EN
        chk_w({tag, "_cnt0"}, 32'(grant_cnt0[d]), 32'h0);
        chk_w({tag, "_cnt1"}, 32'(grant_cnt1[d]), 32'h0);
`endif
    endtask

    task automatic check_rsp(input int d, input string tag, input logic id, input logic [31:0] x,
                             input logic [31:0] y, input logic ovf, input logic carry);
        chk_b({tag, "_valid"}, rsp_valid[d], 1'b1);
        chk_b({tag, "_id"}, rsp_id[d], id);
        chk_w({tag, "_x"}, 32'(rsp_x[d]), x);
        chk_w({tag, "_y"}, 32'(rsp_y[d]), y);
        chk_b({tag, "_ovf"}, rsp_ovf[d], ovf);
        chk_b({tag, "_carry"}, rsp_carry[d], carry);
        chk_w({tag, "_x_vs_alu"}, 32'(rsp_x[d]), 32'(alu_x[d]));
        chk_w({tag, "_y_vs_alu"}, 32'(rsp_y[d]), 32'(alu_y[d]));
        chk_b({tag, "_ovf_vs_alu"}, rsp_ovf[d], alu_ovf[d]);
        chk_b({tag, "_carry_vs_alu"}, rsp_carry[d], alu_carry[d]);
    endtask

    initial begin
        int          e;
        string       p;
        int          lat;
        int          cnt;
        int          ng;
        int          nr;
        int          both;
        logic [3:0]  got;
        logic        last_g;
        logic        found;

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            idle_inputs(d);
        end

        for (int d = 0; d < 2; d++) begin
            e = (d == 0) ? 1 : 3;
            p = $sformatf("e%0d", e);

            // Reset values.
            do_reset(d);
            sample();
            check_reset(d, {p, "_rst"});
            chk_b({p, "_rst_ready0"}, req0_ready[d], 1'b0);

            // Single requester, ADD 33+7, no backpressure.
            drive();
            req0_valid[d] = 1'b1;
            req0_instr[d] = I_ADD_33_7;
            rsp_ready[d]  = 1'b1;
            sample();
            chk_b({p, "_s1_gnt0"}, req0_ready[d], 1'b1);
            chk_b({p, "_s1_gnt1"}, req1_ready[d], 1'b0);
            lat = 0;
            cnt = 0;
            for (int k = 1; k <= e + 1; k++) begin
                drive();
                sample();
                if (req0_ready[d]) cnt++;
                if (rsp_valid[d] && lat == 0) lat = k;
            end
            chk_w({p, "_s1_latency"}, lat, e + 1);
            chk_w({p, "_s1_extra_ready"}, cnt, 0);
            chk_w({p, "_s1_alu_instr"}, 32'(alu_instr[d]), 32'(I_ADD_33_7));
            check_rsp(d, {p, "_s1"}, 1'b0, 32'h28, 32'h0, 1'b0, 1'b0);
            drive();
            req0_valid[d] = 1'b0;
            sample();
            chk_b({p, "_s1_done"}, rsp_valid[d], 1'b0);

            // Both requesters held valid: round-robin from reset starts at 0.
            do_reset(d);
            req0_valid[d] = 1'b1;
            req0_instr[d] = I_ADD_119_57;
            req1_valid[d] = 1'b1;
            req1_instr[d] = I_MUL_17_M11;
            rsp_ready[d]  = 1'b1;
            ng     = 0;
            nr     = 0;
            both   = 0;
            got    = '0;
            last_g = 1'b0;
            for (int k = 0; k < 4 * (e + 2) + 8 && nr < 4; k++) begin
                sample();
                if (req0_ready[d] && req1_ready[d]) both++;
                if (req0_ready[d] || req1_ready[d]) begin
                    if (ng < 4) got[ng] = req1_ready[d];
                    last_g = req1_ready[d];
                    ng++;
                end
                if (rsp_valid[d]) begin
                    if (last_g)
                        check_rsp(d, $sformatf("%s_s2_r%0d", p, nr), 1'b1, 32'h45, 32'hFF, 1'b1, 1'b0);
                    else
                        check_rsp(d, $sformatf("%s_s2_r%0d", p, nr), 1'b0, 32'hB0, 32'h0, 1'b1, 1'b0);
                    nr++;
                end
                drive();
            end
            chk_w({p, "_s2_grants"}, ng, 4);
            chk_w({p, "_s2_order"}, 32'(got), 32'hA);
            chk_w({p, "_s2_responses"}, nr, 4);
            chk_w({p, "_s2_double_grant"}, both, 0);

            // Backpressure: rsp_ready low for 5 RESP cycles, both requesters waiting.
            req0_instr[d] = I_XOR_A5_3C;
            req1_instr[d] = I_AND_F0_3C;
            rsp_ready[d]  = 1'b0;
            sample();
            chk_b({p, "_s3_gnt0"}, req0_ready[d], 1'b1);
            found = 1'b0;
            for (int k = 0; k < e + 4 && !found; k++) begin
                drive();
                sample();
                if (rsp_valid[d]) found = 1'b1;
            end
            chk_b({p, "_s3_rsp_seen"}, found, 1'b1);
            for (int s = 0; s < 5; s++) begin
                check_rsp(d, $sformatf("%s_s3_c%0d", p, s), 1'b0, 32'h99, 32'h0, 1'b0, 1'b0);
                chk_b($sformatf("%s_s3_c%0d_ready0", p, s), req0_ready[d], 1'b0);
                chk_b($sformatf("%s_s3_c%0d_ready1", p, s), req1_ready[d], 1'b0);
                if (s < 4) begin
                    drive();
                    sample();
                end
            end
            drive();
            req0_valid[d] = 1'b0;
            req1_valid[d] = 1'b0;
            rsp_ready[d]  = 1'b1;
            sample();
            chk_b({p, "_s3_accept"}, rsp_valid[d], 1'b1);
            cnt = 0;
            for (int k = 0; k < 6; k++) begin
                drive();
                sample();
                if (rsp_valid[d]) cnt++;
            end
            chk_w({p, "_s3_single_rsp"}, cnt, 0);

            // Reset during EXEC discards the instruction and restores tie priority.
            drive();
            req1_valid[d] = 1'b1;
            req1_instr[d] = I_AND_F0_3C;
            sample();
            chk_b({p, "_s4_gnt1"}, req1_ready[d], 1'b1);
            drive();
            req1_valid[d] = 1'b0;
            rst_n[d]      = 1'b0;
            drive();
            rst_n[d] = 1'b1;
            sample();
            check_reset(d, {p, "_s4_rst"});
            cnt = 0;
            for (int k = 0; k < 8; k++) begin
                drive();
                sample();
                if (rsp_valid[d]) cnt++;
            end
            chk_w({p, "_s4_no_rsp"}, cnt, 0);
            drive();
            req0_valid[d] = 1'b1;
            req0_instr[d] = I_XOR_A5_3C;
            req1_valid[d] = 1'b1;
            req1_instr[d] = I_AND_F0_3C;
            sample();
            chk_b({p, "_s4_tie_gnt0"}, req0_ready[d], 1'b1);
            chk_b({p, "_s4_tie_gnt1"}, req1_ready[d], 1'b0);
            drive();
            idle_inputs(d);
            repeat (e + 3) drive();

`ifdef ALU_ARB_CNT_EN
            // Saturating grant counter: well over 65535 grants to requester 1.
            if (d == 0) begin
                do_reset(d);
                req1_valid[d] = 1'b1;
                req1_instr[d] = I_ADD_33_7;
                rsp_ready[d]  = 1'b1;
                repeat (3 * 70000 + 10) @(posedge clk);
                sample();
                chk_w({p, "_s5_cnt1"}, 32'(grant_cnt1[d]), 32'hFFFF);
                chk_w({p, "_s5_cnt0"}, 32'(grant_cnt0[d]), 32'h0);
                drive();
                idle_inputs(d);
            end
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter EXEC_CYCLES, default 1, meaning the number of cycles alu_instr is held before result capture (legal 1..4).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 The block SHALL have port req0_valid  input  1  requester 0 has an instruction.
REQ-005 The block SHALL have port req0_instr  input  18  requester 0 {opcode[1:0], A[7:0], B[7:0]}.
REQ-006 The block SHALL have port req0_ready  output  1  requester 0 instruction accepted this cycle.
REQ-007 The block SHALL have ports req1_valid, req1_instr and req1_ready, identical to REQ-004 to REQ-006, for requester 1.
REQ-008 The block SHALL have port alu_instr  output  18  registered instruction driven to alu8bit.
REQ-009 The block SHALL have ports alu_x and alu_y  input  8 each, plus alu_ovf and alu_carry  input  1 each, carrying alu8bit X, Y, Overflow and Carry.
REQ-010 The block SHALL have ports rsp_valid  output  1 and rsp_ready  input  1  response handshake.
REQ-011 The block SHALL have ports rsp_id  output  1  requester that owns the response, and rsp_x, rsp_y  output  8, rsp_ovf, rsp_carry  output  1  captured ALU results.

Function
REQ-012 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-013 In IDLE, if any reqN_valid is high, the block SHALL assert reqN_ready for exactly one winner, combinationally in that cycle, load alu_instr and the owner id, and go to EXEC.
REQ-014 Arbitration SHALL be round-robin: if both requesters are valid, the block SHALL grant the one not granted last; a single valid requester SHALL always win.
REQ-015 The block SHALL stay in EXEC for EXEC_CYCLES cycles with alu_instr stable, capture alu_x, alu_y, alu_ovf and alu_carry verbatim on the last EXEC edge, and go to RESP.
REQ-016 In RESP, rsp_valid SHALL be high and all rsp_* fields SHALL be stable until a cycle with rsp_ready high, after which the block SHALL return to IDLE.
REQ-017 reqN_ready SHALL be low in EXEC and RESP; back-to-back grants SHALL therefore be separated by at least EXEC_CYCLES+1 cycles.
REQ-018 Latency from grant to rsp_valid SHALL be EXEC_CYCLES+1 cycles, with no backpressure.
REQ-019 alu_instr SHALL keep its last value in IDLE and RESP.
REQ-020 A reqN_valid that drops without a grant SHALL be ignored; no state is kept for it.

Reset
REQ-021 While rst_n is low at a clk edge, the block SHALL enter IDLE with alu_instr=0, rsp_valid=0, rsp_id=0, rsp_x=rsp_y=0, rsp_ovf=rsp_carry=0, and the last-grant pointer set to 1, so requester 0 wins the first tie.
REQ-022 Reset in EXEC or RESP SHALL discard the in-flight instruction; no response SHALL be produced for it.

Configuration
REQ-023 With ALU_ARB_CNT_EN defined, the block SHALL add output ports grant_cnt0 and grant_cnt1, 16 bits each, that count grants per requester, saturate at 16'hFFFF, and reset to 0.
REQ-024 Without ALU_ARB_CNT_EN, these ports and their counters SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-025 The shared package alu_pkg SHALL hold the opcode constants (OP_ADD=2'b00, OP_MUL=2'b01, OP_AND=2'b10, OP_XOR=2'b11), INSTR_W=18, DATA_W=8, and the FSM state enum.
REQ-026 The round-robin grant logic SHALL be a sub-module named rr_arb2, with inputs req[1:0] and last and output gnt[1:0], and no state of its own.
REQ-027 alu8bit SHALL be instantiated outside this block and not modified.

Verification
REQ-028 The bench SHALL use a real alu8bit beside the arbiter, check every rsp_* against alu8bit outputs for the issued instruction, and run with EXEC_CYCLES=1 and EXEC_CYCLES=3.
REQ-029 Scenario: req0 only with ADD A=33 B=7 and rsp_ready held high -> req0_ready high for 1 cycle, rsp_valid exactly EXEC_CYCLES+1 cycles later, rsp_id=0, rsp fields equal to the ALU result.
REQ-030 Scenario: req0 and req1 held valid together with ADD 119,57 and MUL 17,-11 -> grants in order 0,1,0,1, and rsp_ovf=1 on every ADD response.
REQ-031 Scenario: rsp_ready held low for 5 cycles in RESP -> rsp_valid and fields stable for all 5 cycles, both reqN_ready low, one response only.
REQ-032 Scenario: rst_n low for one cycle during EXEC -> no rsp_valid afterwards, all outputs at reset values, and the next tie granted to requester 0.
REQ-033 Scenario: with ALU_ARB_CNT_EN defined, 70000 grants to req1 -> grant_cnt1=16'hFFFF and grant_cnt0=0.
